pwm_multicanal: RTL

//  NUM_CH-channel PWM generator for servo/actuator drive; successor to the fixed 4-level PWM block.
//  Per-channel duty is a full CNT_W-bit value written at runtime, instead of a 2-bit selected constant.

---
 rtl/pwm_multicanal.sv | 74 +++++++
 1 files changed

// File: rtl/pwm_multicanal.sv
// pwm_multicanal: multi-channel PWM with clamped, double-buffered duty, edge/center alignment and period tick
module pwm_multicanal #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 20,
  parameter int PERIOD = 1000000,
  parameter int DUTY_MAX = 125000,
  parameter int DUTY_RST = 75000,
  parameter bit CENTER = 1'b0,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_duty,
  output logic              wr_ack,
  output logic              clamp,
  output logic              period_tick,
  output logic [NUM_CH-1:0] pwm,
  output logic [NUM_CH-1:0] db_pwm
);
  localparam logic [CNT_W-1:0] PER = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] DRST = CNT_W'(DUTY_RST);
  localparam logic [CNT_W-1:0] SRST = CNT_W'((PERIOD - DUTY_RST) / 2);
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wr_val;
  logic [NUM_CH-1:0] raw;
  logic wrap;
  logic wr_ok;
  logic over;
  assign wrap = enable && cnt == LAST;
  assign wr_ok = wr_en && {1'b0, wr_ch} < NCH;
  assign over = wr_duty > DMAX;
  assign wr_val = over ? DMAX : wr_duty;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      period_tick <= 1'b0;
      wr_ack <= 1'b0;
      clamp <= 1'b0;
      pwm <= '0;
      db_pwm <= '0;
    end else begin
      cnt <= enable && cnt != LAST ? cnt + 1'b1 : '0;
      period_tick <= wrap;
      wr_ack <= wr_ok;
      clamp <= wr_ok && over;
      pwm <= enable ? raw : '0;
      db_pwm <= enable ? raw : '0;
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] start;
    // active/start only move at the wrap (or while stopped) so a pulse is never cut or stretched
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        shadow <= DRST;
        active <= DRST;
        start <= SRST;
      end else begin
        if (!enable || wrap) begin
          active <= shadow;
          start <= (PER - shadow) >> 1;
        end
        if (wr_ok && wr_ch == CH_W'(c)) shadow <= wr_val;
      end
    assign raw[c] = CENTER ? cnt >= start && cnt < start + active : cnt < active;
  end
endmodule
